// File: rtl/cap_array_seq_if.sv
// Capacitor-array calibration port: the sequencer is master, the array (or its model) is slave.
interface cap_array_seq_if #(
  parameter int POS_W  = 5,
  parameter int COEF_W = 3
);
  logic              cap_rstn;
  logic              cap_wena;
  logic              cap_rena;
  logic              cap_read_ack;
  logic [POS_W-1:0]  cap_position;
  logic [COEF_W-1:0] cap_coefficent_in;
  logic [COEF_W-1:0] cap_rdata;
  logic              cap_rvalid;

  modport master (
    output cap_rstn, cap_wena, cap_rena, cap_read_ack, cap_position, cap_coefficent_in,
    input  cap_rdata, cap_rvalid
  );
  modport slave (
    input  cap_rstn, cap_wena, cap_rena, cap_read_ack, cap_position, cap_coefficent_in,
    output cap_rdata, cap_rvalid
  );
endinterface

// File: rtl/cap_array_seq.sv
// Calibration sequencer: reset the cap array, write one coefficient per position,
// optionally read every position back and flag mismatches / missing responses.
module cap_array_seq #(
  parameter int N_POS         = 32,
  parameter int POS_W         = 5,
  parameter int COEF_W        = 3,
  parameter int RST_CYCLES    = 16,
  parameter int STROBE_CYCLES = 4,
  parameter int ACK_TIMEOUT   = 255
) (
  input  logic                    clk_50M,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [N_POS*COEF_W-1:0] coef_table_i,
  cap_array_seq_if.master         cap,
  output logic                    cap_comp_ena_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_mismatch_o,
  output logic                    err_timeout_o,
  output logic [POS_W:0]          mismatch_cnt_o,
  output logic [2:0]              state_o
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // One counter serves the reset length, the write phase offset and the ack wait.
  localparam int CMAX1 = (RST_CYCLES > ACK_TIMEOUT) ? RST_CYCLES : ACK_TIMEOUT;
  localparam int CMAX  = (CMAX1 > STROBE_CYCLES + 1) ? CMAX1 : STROBE_CYCLES + 1;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_POS - 1);

  state_e                         state_q;
  logic                           mode_q;
  logic [N_POS-1:0][COEF_W-1:0]   tbl_q;
  logic [CNT_W-1:0]               cnt_q;
  logic [POS_W-1:0]               pos_q;
  logic [COEF_W-1:0]              coef_q;
  logic                           rstn_q, wena_q, rena_q, ack_q, comp_q, errm_q, errt_q;
  logic [POS_W:0]                 mcnt_q;
  logic [POS_W-1:0]               pos_nxt;

  assign pos_nxt = pos_q + 1'b1;

  always_ff @(posedge clk_50M or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      tbl_q   <= '0;
      cnt_q   <= '0;
      pos_q   <= '0;
      coef_q  <= '0;
      rstn_q  <= 1'b1;
      wena_q  <= 1'b0;
      rena_q  <= 1'b0;
      ack_q   <= 1'b0;
      comp_q  <= 1'b0;
      errm_q  <= 1'b0;
      errt_q  <= 1'b0;
      mcnt_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q <= S_RESET;
            mode_q  <= mode_i;
            tbl_q   <= coef_table_i;
            errm_q  <= 1'b0;
            errt_q  <= 1'b0;
            mcnt_q  <= '0;
            comp_q  <= 1'b0;
            rstn_q  <= 1'b0;
            pos_q   <= '0;
            cnt_q   <= CNT_W'(RST_CYCLES - 1);
          end
        end
        S_RESET: begin
          if (cnt_q == '0) begin
            state_q <= S_WRITE;
            rstn_q  <= 1'b1;
            pos_q   <= '0;
            coef_q  <= tbl_q[0];
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_WRITE: begin
          // cnt_q is the offset inside the set-up / strobe / hold window
          if (cnt_q == CNT_W'(STROBE_CYCLES + 1)) begin
            cnt_q <= '0;
            if (pos_q == LAST) begin
              pos_q  <= '0;
              coef_q <= '0;
              if (mode_q) begin
                state_q <= S_READ;
                rena_q  <= 1'b1;
              end else begin
                state_q <= S_DONE;
                comp_q  <= ~(errm_q | errt_q);
              end
            end else begin
              pos_q  <= pos_nxt;
              coef_q <= tbl_q[pos_nxt];
            end
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            wena_q <= (cnt_q < CNT_W'(STROBE_CYCLES));
          end
        end
        S_READ: begin
          if (ack_q) begin
            if (pos_q == LAST) begin
              state_q <= S_DONE;
              pos_q   <= '0;
              comp_q  <= ~(errm_q | errt_q);
            end else begin
              pos_q  <= pos_nxt;
              rena_q <= 1'b1;
              cnt_q  <= '0;
            end
          end else if (cap.cap_rvalid) begin
            rena_q <= 1'b0;
            ack_q  <= 1'b1;
            if (cap.cap_rdata != tbl_q[pos_q]) begin
              errm_q <= 1'b1;
              mcnt_q <= mcnt_q + 1'b1;
            end
          end else if (cnt_q == CNT_W'(ACK_TIMEOUT)) begin
            // responder gave up: abandon the remaining positions
            state_q <= S_DONE;
            rena_q  <= 1'b0;
            errt_q  <= 1'b1;
            pos_q   <= '0;
            comp_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cap.cap_rstn          = rstn_q;
  assign cap.cap_wena          = wena_q;
  assign cap.cap_rena          = rena_q;
  assign cap.cap_read_ack      = ack_q;
  assign cap.cap_position      = pos_q;
  assign cap.cap_coefficent_in = coef_q;

  assign cap_comp_ena_o = comp_q;
  assign busy_o         = (state_q == S_RESET) || (state_q == S_WRITE) || (state_q == S_READ);
  assign done_o         = (state_q == S_DONE);
  assign err_mismatch_o = errm_q;
  assign err_timeout_o  = errt_q;
  assign mismatch_cnt_o = mcnt_q;
  assign state_o        = state_q;
endmodule

// File: tb/tb_cap_array_seq.sv
// Randomized bench: a timeline model derived from the cycle formulas predicts every
// strobe, read request, ack and final flag of each sequence.
module tb_cap_array_seq;
  localparam int N_POS = 32, POS_W = 5, COEF_W = 3;
  localparam int R = 16, S = 4, T = 255;
  localparam int W0 = 1 + R + N_POS*(S+2);

  logic clk_50M = 1'b0, rst = 1'b1, start_i = 1'b0, mode_i = 1'b0;
  logic [N_POS*COEF_W-1:0] coef_table_i = '0;
  logic cap_comp_ena_o, busy_o, done_o, err_mismatch_o, err_timeout_o;
  logic [POS_W:0] mismatch_cnt_o;
  logic [2:0] state_o;

  cap_array_seq_if #(.POS_W(POS_W), .COEF_W(COEF_W)) cap ();

  cap_array_seq #(.N_POS(N_POS), .POS_W(POS_W), .COEF_W(COEF_W), .RST_CYCLES(R),
                  .STROBE_CYCLES(S), .ACK_TIMEOUT(T)) dut (
    .clk_50M(clk_50M), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .coef_table_i(coef_table_i), .cap(cap), .cap_comp_ena_o(cap_comp_ena_o),
    .busy_o(busy_o), .done_o(done_o), .err_mismatch_o(err_mismatch_o),
    .err_timeout_o(err_timeout_o), .mismatch_cnt_o(mismatch_cnt_o), .state_o(state_o)
  );

  always #10 clk_50M = ~clk_50M;

  int checks = 0, fails = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int ncyc = 0, t0 = 0;
  initial forever begin
    @(posedge clk_50M);
    ncyc++;
  end

  // responder config and the model's copy of the table
  logic [COEF_W-1:0] tbl [N_POS];
  bit r_bad [N_POS];
  int r_lat = 0, r_silent = N_POS;
  bit r_noise = 1'b0;

  initial begin : resp
    int wc;
    wc = 0;
    cap.cap_rvalid = 1'b0;
    cap.cap_rdata = '0;
    forever begin
      @(posedge clk_50M); #1;
      if (cap.cap_rena) begin
        cap.cap_rvalid = 1'b0;
        if (int'(cap.cap_position) < r_silent && wc == r_lat) begin
          cap.cap_rvalid = 1'b1;
          cap.cap_rdata = tbl[cap.cap_position] ^ COEF_W'(r_bad[cap.cap_position]);
          wc = 0;
        end else wc++;
      end else begin
        wc = 0;
        cap.cap_rvalid = r_noise ? 1'($urandom) : 1'b0;
        cap.cap_rdata = COEF_W'($urandom);
      end
    end
  end

  // observed event log, times relative to the start cycle
  int w_rise[$], w_len[$], w_pos[$], w_coef[$], r_rise[$], a_cyc[$], a_pos[$];
  int rstn_lo, rstn_first, d_cyc, to_cyc, unstable, w_start, cur_pos, cur_coef;
  bit in_w;
  logic p_wena = 1'b0, p_rena = 1'b0, p_done = 1'b0, p_errt = 1'b0;

  task automatic clr_log();
    w_rise.delete(); w_len.delete(); w_pos.delete(); w_coef.delete();
    r_rise.delete(); a_cyc.delete(); a_pos.delete();
    rstn_lo = 0; rstn_first = -1; d_cyc = -1; to_cyc = -1; unstable = 0; in_w = 1'b0;
  endtask

  initial begin : mon
    int rel;
    clr_log();
    forever begin
      @(negedge clk_50M);
      rel = ncyc - t0;
      if (!cap.cap_rstn) begin
        if (rstn_lo == 0) rstn_first = rel;
        rstn_lo++;
      end
      if (cap.cap_wena && !p_wena) begin
        w_rise.push_back(rel);
        w_pos.push_back(int'(cap.cap_position));
        w_coef.push_back(int'(cap.cap_coefficent_in));
        w_start = rel; cur_pos = int'(cap.cap_position);
        cur_coef = int'(cap.cap_coefficent_in); in_w = 1'b1;
      end
      if (in_w && (int'(cap.cap_position) != cur_pos || int'(cap.cap_coefficent_in) != cur_coef))
        unstable++;
      if (!cap.cap_wena && p_wena) begin
        w_len.push_back(rel - w_start);
        in_w = 1'b0;
      end
      if (cap.cap_rena && !p_rena) r_rise.push_back(rel);
      if (cap.cap_read_ack) begin
        a_cyc.push_back(rel);
        a_pos.push_back(int'(cap.cap_position));
      end
      if (done_o && !p_done && d_cyc < 0) d_cyc = rel;
      if (err_timeout_o && !p_errt) to_cyc = rel;
      p_wena = cap.cap_wena; p_rena = cap.cap_rena; p_done = done_o; p_errt = err_timeout_o;
    end
  end

  task automatic kick(input bit md);
    mode_i = md;
    for (int p = 0; p < N_POS; p++) coef_table_i[p*COEF_W +: COEF_W] = tbl[p];
    @(negedge clk_50M); start_i = 1'b1; #1; t0 = ncyc; clr_log();
    @(posedge clk_50M); #1; start_i = 1'b0;
    // inputs must have been latched; scramble them
    mode_i = 1'($urandom);
    for (int p = 0; p < N_POS; p++) coef_table_i[p*COEF_W +: COEF_W] = COEF_W'($urandom);
  endtask

  task automatic run(input bit md, input int lat, input int silent, input int poke);
    int k, mm, exp_done, n_rena, rel;
    bit to;
    r_lat = lat; r_silent = silent;
    kick(md);
    @(negedge clk_50M);
    chk("c1_state", state_o, 1);
    chk("c1_rstn", cap.cap_rstn, 0);
    chk("c1_flags", {err_mismatch_o, err_timeout_o, done_o, busy_o}, 4'b0001);
    chk("c1_mcnt", mismatch_cnt_o, 0);
    rel = 1;
    while (d_cyc < 0 && rel < 3000) begin
      @(negedge clk_50M);
      rel = ncyc - t0;
      start_i = (rel == poke);
    end
    start_i = 1'b0;
    if (d_cyc < 0) begin
      chk("done_wait", 0, 1);
      return;
    end
    k  = md ? ((silent < N_POS) ? silent : N_POS) : 0;
    to = md && (silent < N_POS);
    mm = 0;
    for (int p = 0; p < k; p++) if (r_bad[p]) mm++;
    exp_done = !md ? W0 : (to ? W0 + k*(lat+2) + T + 1 : W0 + N_POS*(lat+2));
    n_rena = !md ? 0 : (to ? k + 1 : N_POS);

    chk("done_cyc", d_cyc, exp_done);
    chk("rstn_len", rstn_lo, R);
    chk("rstn_first", rstn_first, 1);
    chk("wena_cnt", w_rise.size(), N_POS);
    chk("wr_unstable", unstable, 0);
    for (int p = 0; p < N_POS && p < w_rise.size(); p++) begin
      chk($sformatf("wena_rise[%0d]", p), w_rise[p], 2 + R + p*(S+2));
      chk($sformatf("wena_pos[%0d]", p), w_pos[p], p);
      chk($sformatf("wena_coef[%0d]", p), w_coef[p], int'(tbl[p]));
      if (p < w_len.size()) chk($sformatf("wena_len[%0d]", p), w_len[p], S);
    end
    chk("rena_cnt", r_rise.size(), n_rena);
    for (int p = 0; p < n_rena && p < r_rise.size(); p++)
      chk($sformatf("rena_rise[%0d]", p), r_rise[p], W0 + p*(lat+2));
    chk("ack_cnt", a_cyc.size(), k);
    for (int p = 0; p < k && p < a_cyc.size(); p++) begin
      chk($sformatf("ack_cyc[%0d]", p), a_cyc[p], W0 + p*(lat+2) + lat + 1);
      chk($sformatf("ack_pos[%0d]", p), a_pos[p], p);
    end
    chk("to_cyc", to_cyc, to ? exp_done : -1);
    chk("err_mismatch", err_mismatch_o, mm > 0);
    chk("err_timeout", err_timeout_o, to);
    chk("mcnt", mismatch_cnt_o, mm);
    chk("comp_ena", cap_comp_ena_o, !(mm > 0 || to));
    chk("end_state", state_o, 4);
    chk("end_busy_done", {busy_o, done_o}, 2'b01);
    chk("end_pos_rena", {cap.cap_position, cap.cap_rena}, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rstn"}, cap.cap_rstn, 1);
    chk({tag, "_strobes"}, {cap.cap_wena, cap.cap_rena, cap.cap_read_ack}, 0);
    chk({tag, "_pos_coef"}, {cap.cap_position, cap.cap_coefficent_in}, 0);
    chk({tag, "_flags"}, {cap_comp_ena_o, busy_o, done_o, err_mismatch_o, err_timeout_o}, 0);
    chk({tag, "_mcnt"}, mismatch_cnt_o, 0);
    chk({tag, "_state"}, state_o, 0);
  endtask

  initial begin
    for (int p = 0; p < N_POS; p++) begin
      tbl[p] = COEF_W'(p % 8);
      r_bad[p] = 1'b0;
    end
    repeat (3) @(negedge clk_50M);
    chk_reset_vals("por");
    rst = 1'b0;
    repeat (2) @(negedge clk_50M);

    run(1'b0, 0, N_POS, 0);           // write only, table p%8
    run(1'b1, 3, N_POS, 0);           // echo responder, L=3
    r_bad[7] = 1'b1;
    run(1'b1, 3, N_POS, 0);           // position 7 corrupted
    r_bad[7] = 1'b0;
    r_noise = 1'b1;
    run(1'b1, 3, 10, 0);              // silent from position 10, restart clears flags

    // async reset in the middle of the write of position 5
    kick(1'b0);
    repeat (1 + R + 5*(S+2) + 1) @(negedge clk_50M);
    chk("pre_rst_wena", {cap.cap_wena, cap.cap_position}, {1'b1, 5'd5});
    @(posedge clk_50M); #2; rst = 1'b1; #1;
    chk_reset_vals("midrst");
    @(negedge clk_50M); rst = 1'b0;
    run(1'b0, 0, N_POS, 0);

    run(1'b1, 1, N_POS, 100);         // start while busy is ignored

    repeat (6) begin
      for (int p = 0; p < N_POS; p++) begin
        tbl[p] = COEF_W'($urandom);
        r_bad[p] = ($urandom_range(0, 7) == 0);
      end
      r_noise = 1'($urandom);
      run(1'($urandom), $urandom_range(0, 4),
          ($urandom_range(0, 2) == 0) ? $urandom_range(0, N_POS-1) : N_POS,
          ($urandom_range(0, 1) == 0) ? $urandom_range(2, W0-2) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
